// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 divider (binary64/binary32), one quotient bit per cycle,
// restoring radix-2, round-to-nearest-even, subnormals flushed to zero.
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   operand handshake; in1 = dividend, in2 = divisor
//   out_valid/out_ready result handshake; out = quotient
//   flags               {invalid, div_by_zero, overflow, underflow, inexact}
module fp_div_seq #(
    parameter int BUS_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_WIDTH-1:0] in1,
    input  logic [BUS_WIDTH-1:0] in2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out,
    output logic [4:0]           flags
);
    localparam int MS    = (BUS_WIDTH == 64) ? 52 : 23;
    localparam int ES    = (BUS_WIDTH == 64) ? 11 : 8;
    localparam int BIAS  = (1 << (ES - 1)) - 1;
    localparam int QBITS = MS + 3;
    localparam int EW    = ES + 2;
    localparam int CW    = $clog2(QBITS);

    localparam logic [BUS_WIDTH-1:0] QNAN =
        {1'b0, {ES{1'b1}}, 1'b1, {(MS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

    state_t state, next_state;

    logic [MS+1:0]  rem_q;
    logic [MS:0]    div_q;
    logic [QBITS-1:0] quo_q;
    logic [EW-1:0]  exp_q;
    logic           sign_q;
    logic [CW-1:0]  cnt_q;

    // operand decode
    logic          s1, s2, sgn;
    logic [ES-1:0] e1, e2;
    logic [MS-1:0] m1, m2;
    logic          nan1, nan2, inf1, inf2, zero1, zero2, special;
    logic          accept, handshake;

    assign s1 = in1[BUS_WIDTH-1];
    assign s2 = in2[BUS_WIDTH-1];
    assign e1 = in1[BUS_WIDTH-2 -: ES];
    assign e2 = in2[BUS_WIDTH-2 -: ES];
    assign m1 = in1[MS-1:0];
    assign m2 = in2[MS-1:0];
    assign sgn = s1 ^ s2;

    assign nan1  = (&e1) && (|m1);
    assign nan2  = (&e2) && (|m2);
    assign inf1  = (&e1) && !(|m1);
    assign inf2  = (&e2) && !(|m2);
    assign zero1 = (e1 == '0);
    assign zero2 = (e2 == '0);
    assign special = nan1 | nan2 | inf1 | inf2 | zero1 | zero2;

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    logic [BUS_WIDTH-1:0] spec_res;
    logic [4:0]           spec_fl;

    // order matters: inf/0 is inf without div_by_zero
    always_comb begin
        spec_res = '0;
        spec_fl  = '0;
        priority case (1'b1)
            nan1 | nan2 | (zero1 & zero2) | (inf1 & inf2): begin
                spec_res = QNAN;
                spec_fl  = 5'b10000;
            end
            inf1: spec_res = {sgn, {ES{1'b1}}, {MS{1'b0}}};
            zero2: begin
                spec_res = {sgn, {ES{1'b1}}, {MS{1'b0}}};
                spec_fl  = 5'b01000;
            end
            default: spec_res = {sgn, {(BUS_WIDTH-1){1'b0}}};
        endcase
    end

    // one restoring step
    logic [MS+2:0] trial;
    logic          q_bit;
    logic [MS+1:0] rem_next;

    assign trial    = {1'b0, rem_q} - {2'b00, div_q};
    assign q_bit    = !trial[MS+2];
    assign rem_next = q_bit ? {trial[MS:0], 1'b0} : {rem_q[MS:0], 1'b0};

    // normalise, round, range-check
    logic [QBITS-1:0]     qn;
    logic [EW-1:0]        en, er;
    logic [MS:0]          keep;
    logic                 guard, sticky, rup;
    logic [MS+1:0]        sig;
    logic [MS-1:0]        mant;
    logic [BUS_WIDTH-1:0] rnd_res;
    logic [4:0]           rnd_fl;

    always_comb begin
        qn     = quo_q[QBITS-1] ? quo_q : {quo_q[QBITS-2:0], 1'b0};
        en     = quo_q[QBITS-1] ? exp_q : exp_q - EW'(1);
        keep   = qn[QBITS-1:2];
        guard  = qn[1];
        sticky = qn[0] | (|rem_q);
        rup    = guard & (sticky | keep[0]);
        sig    = {1'b0, keep} + (MS+2)'(rup);
        er     = sig[MS+1] ? en + EW'(1) : en;
        mant   = sig[MS+1] ? sig[MS:1] : sig[MS-1:0];
        rnd_res = {sign_q, er[ES-1:0], mant};
        rnd_fl  = {4'b0000, guard | sticky};
        // exponent is two's complement in EW bits
        if (!er[EW-1] && (er >= EW'(2 * BIAS + 1))) begin
            rnd_res = {sign_q, {ES{1'b1}}, {MS{1'b0}}};
            rnd_fl  = 5'b00101;
        end else if (er[EW-1] || (er == '0)) begin
            rnd_res = {sign_q, {(BUS_WIDTH-1){1'b0}}};
            rnd_fl  = 5'b00011;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:   if (accept) next_state = special ? DONE : DIVIDE;
            DIVIDE: if (cnt_q == CW'(QBITS - 1)) next_state = ROUND;
            ROUND:  next_state = DONE;
            DONE:   if (handshake) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q     <= '0;
            div_q     <= '0;
            quo_q     <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            cnt_q     <= '0;
            out       <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    sign_q <= sgn;
                    if (special) begin
                        out   <= spec_res;
                        flags <= spec_fl;
                    end else begin
                        rem_q <= {2'b01, m1};
                        div_q <= {1'b1, m2};
                        exp_q <= {2'b00, e1} - {2'b00, e2} + EW'(BIAS);
                        quo_q <= '0;
                        cnt_q <= '0;
                    end
                end
                DIVIDE: begin
                    rem_q <= rem_next;
                    quo_q <= {quo_q[QBITS-2:0], q_bit};
                    cnt_q <= cnt_q + CW'(1);
                end
                ROUND: begin
                    out       <= rnd_res;
                    flags     <= rnd_fl;
                    out_valid <= 1'b1;
                end
                // special results land here with out_valid still low
                DONE: out_valid <= !handshake;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: binary64 and binary32 instances, directed vectors
// plus stall and mid-divide reset sequences.
module tb_fp_div_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv64, ir64, ov64, ordy;
    logic [63:0] a64, b64, o64;
    logic [4:0]  f64;
    logic        iv32, ir32, ov32;
    logic [31:0] a32, b32, o32;
    logic [4:0]  f32;

    int tests = 0;
    int fails = 0;

    fp_div_seq #(.BUS_WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64),
        .in1(a64), .in2(b64), .out_valid(ov64), .out_ready(ordy),
        .out(o64), .flags(f64)
    );

    fp_div_seq #(.BUS_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .in1(a32), .in2(b32), .out_valid(ov32), .out_ready(ordy),
        .out(o32), .flags(f32)
    );

    typedef struct {
        bit          w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [4:0]  f;
        int          lat;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_op(input bit w, input logic [63:0] a,
                         input logic [63:0] b, input bit rdy,
                         output logic [63:0] r, output logic [4:0] f,
                         output int lat);
        @(negedge clk);
        ordy = rdy;
        if (w) begin
            a32 = a[31:0]; b32 = b[31:0]; iv32 = 1'b1;
        end else begin
            a64 = a; b64 = b; iv64 = 1'b1;
        end
        @(posedge clk);
        #1;
        iv32 = 1'b0; iv64 = 1'b0;
        a64 = ~a64; b64 = ~b64; a32 = ~a32; b32 = ~b32;
        lat = 0;
        while (!(w ? ov32 : ov64) && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = w ? {32'h0, o32} : o64;
        f = w ? f32 : f64;
    endtask

    logic [63:0] r, s_out;
    logic [4:0]  f, s_fl;
    int          lat;
    bit          seen;

    initial begin
        vt[0]  = '{0, 64'h4018000000000000, 64'h4000000000000000,
                   64'h4008000000000000, 5'b00000, 56};
        vt[1]  = '{0, 64'h3FF0000000000000, 64'h4008000000000000,
                   64'h3FD5555555555555, 5'b00001, 56};
        vt[2]  = '{0, 64'h3FF0000000000000, 64'h3FF8000000000000,
                   64'h3FE5555555555555, 5'b00001, 56};
        vt[3]  = '{0, 64'h3FF0000000000000, 64'h0,
                   64'h7FF0000000000000, 5'b01000, 1};
        vt[4]  = '{0, 64'h0, 64'h0,
                   64'h7FF8000000000000, 5'b10000, 1};
        vt[5]  = '{0, 64'hBFF0000000000000, 64'h7FF0000000000000,
                   64'h8000000000000000, 5'b00000, 1};
        vt[6]  = '{0, 64'h7FE0000000000000, 64'h3FE0000000000000,
                   64'h7FF0000000000000, 5'b00101, 56};
        vt[7]  = '{0, 64'h0010000000000000, 64'h4000000000000000,
                   64'h0000000000000000, 5'b00011, 56};
        vt[8]  = '{0, 64'h7FF8000000000001, 64'h3FF0000000000000,
                   64'h7FF8000000000000, 5'b10000, 1};
        vt[9]  = '{0, 64'hFFF0000000000000, 64'h4000000000000000,
                   64'hFFF0000000000000, 5'b00000, 1};
        vt[10] = '{0, 64'h0, 64'hC000000000000000,
                   64'h8000000000000000, 5'b00000, 1};
        vt[11] = '{1, 64'h40C00000, 64'h40000000,
                   64'h40400000, 5'b00000, 27};
        vt[12] = '{1, 64'h3F800000, 64'h40400000,
                   64'h3EAAAAAB, 5'b00001, 27};
        vt[13] = '{1, 64'h7F800000, 64'h7F800000,
                   64'h7FC00000, 5'b10000, 1};
        vt[14] = '{0, 64'hC008000000000000, 64'h3FF0000000000000,
                   64'hC008000000000000, 5'b00000, 56};
        vt[15] = '{0, 64'h7FF0000000000000, 64'h0,
                   64'h7FF0000000000000, 5'b00000, 1};

        rst = 1'b1; ordy = 1'b0;
        iv64 = 1'b0; iv32 = 1'b0;
        a64 = '0; b64 = '0; a32 = '0; b32 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_ready", {62'h0, ir64, ir32}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready_valid", {60'h0, ir64, ov64, ir32, ov32}, 64'hA);
        chk("rst_out64", o64, 64'h0);
        chk("rst_flags", {54'h0, f64, f32}, 64'h0);

        for (int i = 0; i < 16; i++) begin
            do_op(vt[i].w, vt[i].a, vt[i].b, 1'b1, r, f, lat);
            chk($sformatf("v%0d_out", i), r, vt[i].q);
            chk($sformatf("v%0d_flags", i), {59'h0, f}, {59'h0, vt[i].f});
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vt[i].lat));
            @(posedge clk);
            #1;
            if (vt[i].w)
                chk($sformatf("v%0d_idle", i), {62'h0, ir32, ov32}, 64'h2);
            else
                chk($sformatf("v%0d_idle", i), {62'h0, ir64, ov64}, 64'h2);
        end

        // hold the result with out_ready low
        do_op(1'b0, 64'h4018000000000000, 64'h4000000000000000, 1'b0,
              s_out, s_fl, lat);
        chk("stall_out", s_out, 64'h4008000000000000);
        chk("stall_lat", 64'(lat), 64'd56);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_out", k), o64, s_out);
            chk($sformatf("stall%0d_hs", k), {57'h0, ov64, ir64, f64},
                {57'h0, 1'b1, 1'b0, s_fl});
        end
        @(negedge clk);
        ordy = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_release", {62'h0, ir64, ov64}, 64'h2);

        // reset in the middle of the iteration phase
        @(negedge clk);
        a64 = 64'h3FF0000000000000; b64 = 64'h4008000000000000;
        iv64 = 1'b1;
        @(posedge clk);
        #1;
        iv64 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {62'h0, ov64, ir64}, 64'h0);
        chk("mid_rst_out", o64, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", {62'h0, ir64, ov64}, 64'h2);
        seen = 1'b0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk);
            #1;
            if (ov64) seen = 1'b1;
        end
        chk("mid_rst_no_output", {63'h0, seen}, 64'h0);

        do_op(1'b0, 64'h3FF0000000000000, 64'h3FF8000000000000, 1'b1,
              r, f, lat);
        chk("post_rst_out", r, 64'h3FE5555555555555);
        chk("post_rst_lat", 64'(lat), 64'd56);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fp_div_seq.md
# fp_div_seq

Sequential, parametrised IEEE-754 floating-point divider for the FPU, supporting binary64 and binary32 through one width parameter. It computes one quotient bit per clock with a restoring radix-2 datapath, rounds to nearest-even and reports exception flags. It sits behind the FPU issue logic with valid/ready handshakes on both sides, so the long-latency divide does not stall the single-cycle FP units.

## Interface
- `BUS_WIDTH`, 64; operand/result width, legal values 64 (binary64) and 32 (binary32).
- Derived constants: MANTISSA_SIZE = 52/23, EXPONENT_SIZE = 11/8, BIAS = 1023/127, QBITS = MANTISSA_SIZE+3 (55/26).
- `clk` input 1; the single clock, all state updates on its rising edge.
- `rst` input 1; asynchronous, active-high reset.
- `in_valid` input 1; operands present.
- `in_ready` output 1; divider can accept an operation.
- `in1` input BUS_WIDTH; dividend.
- `in2` input BUS_WIDTH; divisor.
- `out_valid` output 1; result and flags valid.
- `out_ready` input 1; consumer takes the result.
- `out` output BUS_WIDTH; quotient.
- `flags` output 5; {invalid, div_by_zero, overflow, underflow, inexact}.

## Operation
- States: IDLE, DIVIDE, ROUND, DONE. Reset value: IDLE, `out`=0, `flags`=0, `out_valid`=0, iteration counter 0.
- `in_ready` = (state==IDLE) and not `rst`. Accept = `in_valid & in_ready`. Operands are registered on accept, and later changes to `in1`/`in2` are ignored.
- Input classification on accept: exponent all-ones with mantissa≠0 is NaN; exponent all-ones with mantissa=0 is inf; exponent=0 is zero (subnormals flush to zero, sign kept).
- Special cases go IDLE→DONE, and the result is registered on the accept edge:
  - any NaN, 0/0 or inf/inf: canonical +NaN (0x7FF8000000000000 / 0x7FC00000), invalid=1;
  - finite≠0 / 0: ±inf, div_by_zero=1;
  - inf / finite: ±inf, no flag;
  - 0 / finite≠0, or finite / inf: ±0, no flag.
- For every result except NaN, the sign is S1^S2.
- Normal case goes IDLE→DIVIDE:
  - Remainder is initialised to {1,M1}. Divisor is {1,M2}. Exponent = E1−E2+BIAS, held signed in EXPONENT_SIZE+2 bits.
  - DIVIDE runs exactly QBITS cycles. Each cycle computes trial = rem−div. If trial≥0, the quotient bit is 1 and rem=trial<<1. Otherwise the quotient bit is 0 and rem=rem<<1. The bit is shifted into the quotient register, MSB first.
  - After the last iteration the state moves to ROUND.
- ROUND (one cycle):
  - If quotient MSB=0 (quotient <1), shift the quotient left 1 and decrement the exponent.
  - The kept significand is MANTISSA_SIZE+1 bits. Guard = next bit. Sticky = OR of the remaining quotient bits and (rem≠0).
  - Round up when guard & (sticky | lsb). A mantissa carry-out increments the exponent and shifts the significand.
  - inexact = guard|sticky.
  - Exponent ≥ 2·BIAS+1: ±inf, overflow=1, inexact=1.
  - Exponent ≤ 0: ±0 (flush), underflow=1, inexact=1.
  - Otherwise pack {sign, exp[EXPONENT_SIZE-1:0], mantissa}. Result and flags are registered, then the state moves to DONE.
- DONE: `out_valid`=1. `out`/`flags` stay stable until `out_valid & out_ready`, which returns the state to IDLE. `out_valid` drops on that edge.
- Reset mid-operation: immediate return to IDLE and all outputs cleared. The in-flight operation is discarded and produces no output.

## Timing
- Accept edge = cycle 0.
- Normal operands: `out_valid` is high after edge QBITS+1 (56 cycles for 64-bit, 27 cycles for 32-bit).
- Special operands: `out_valid` is high after edge 1.
- `out_valid` is registered. `in_ready` depends on the state register only, never on `in_valid`/`out_ready`.
- No overlap: a new operation is accepted at the earliest one cycle after the result handshake, because IDLE must be re-entered first. Minimum normal-case period is QBITS+3 cycles.
- While `out_ready`=0 in DONE there is no limit on the stall. `in_ready` stays 0 and outputs stay frozen.

## Test plan
- 64-bit: 0x4018000000000000 / 0x4000000000000000 (6/2), `out_ready`=1 → 0x4008000000000000, flags=0, `out_valid` 56 cycles after accept, `in_ready` back to 1 one cycle later.
- 64-bit: 0x3FF0000000000000 / 0x4008000000000000 (1/3) → 0x3FD5555555555555, inexact=1. Also 0x3FF0000000000000 / 0x3FF8000000000000 (1/1.5) → 0x3FE5555555555555, which exercises the normalise-decrement path.
- 64-bit specials, each with `out_valid` 1 cycle after accept:
  - 0x3FF0000000000000 / 0 → 0x7FF0000000000000, div_by_zero;
  - 0 / 0 → 0x7FF8000000000000, invalid;
  - 0xBFF0000000000000 / 0x7FF0000000000000 → 0x8000000000000000.
- 64-bit range limits:
  - 0x7FE0000000000000 / 0x3FE0000000000000 → 0x7FF0000000000000, overflow+inexact;
  - 0x0010000000000000 / 0x4000000000000000 → 0x0000000000000000, underflow+inexact.
- Handshake:
  - Hold `out_ready`=0 for 10 cycles in DONE; `out`/`flags`/`out_valid` must stay stable and `in_ready`=0.
  - Assert `rst` at iteration 20 of DIVIDE; `out_valid`=0 immediately and `in_ready`=1 after release.
- 32-bit instance: 0x40C00000 / 0x40000000 → 0x40400000, latency 27. 0x3F800000 / 0x40400000 → 0x3EAAAAAB, inexact=1.
